// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte-level command handshake between a client and the PS/2 host transmitter.
//   tx_data  - byte to send, LSB first (client -> transmitter)
//   tx_valid - tx_data is valid (client -> transmitter)
//   tx_ready - transmitter can accept a byte (transmitter -> client)
//   busy     - a transfer is in progress (transmitter -> client)
//   tx_done  - one-cycle pulse, transfer acknowledged by the device (transmitter -> client)
//   tx_error - one-cycle pulse, transfer failed: timeout or missing ack (transmitter -> client)
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  busy,
      input  tx_done,
      input  tx_error
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output busy,
      output tx_done,
      output tx_error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Takes one command byte over a valid/ready
// handshake, performs the request-to-send sequence (clock inhibit, start bit), shifts out
// 8 data bits, odd parity and stop on device clock falling edges, then checks the device ack.
// The PS/2 lines are only ever pulled low through open-drain enables.
//   clock       - system clock (50 MHz)
//   anti_reset  - asynchronous active-low reset
//   tx_if       - command handshake and status (slave side)
//   ps2_clk_in  - raw ps2_clk pin level
//   ps2_data_in - raw ps2_data pin level
//   ps2_clk_oe  - 1 pulls ps2_clk low, 0 leaves it high-Z
//   ps2_data_oe - 1 pulls ps2_data low, 0 leaves it high-Z
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic         clock,
   input  logic         anti_reset,
   ps2_host_tx_if.slave tx_if,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

   localparam int unsigned IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

   typedef enum logic [2:0] {
      StIdle, StInhibit, StSend, StAck, StWaitIdle, StDone
   } state_e;

   // Input conditioning: index 0 is ps2_clk, index 1 is ps2_data.
   logic [1:0]    sync1_q, sync2_q, filt_q;
   logic [FW-1:0] fcnt_q [2];
   logic          clk_prev_q;

   always_ff @(posedge clock or negedge anti_reset) begin
      if (!anti_reset) begin
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         filt_q     <= 2'b11;
         fcnt_q[0]  <= '0;
         fcnt_q[1]  <= '0;
         clk_prev_q <= 1'b1;
      end else begin
         sync1_q    <= {ps2_data_in, ps2_clk_in};
         sync2_q    <= sync1_q;
         clk_prev_q <= filt_q[0];
         for (int i = 0; i < 2; i++) begin
            // Level flips only after FILTER_LEN consecutive disagreeing samples.
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
               filt_q[i] <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + FW'(1);
            end
         end
      end
   end

   logic fall;
   logic lines_idle;
   assign fall       = clk_prev_q & ~filt_q[0];
   assign lines_idle = &filt_q;

   state_e        state_q, state_d;
   logic [IW-1:0] inh_cnt_q, inh_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic          data_oe_q, data_oe_d;
   logic          ack_q, ack_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          inh_last;
   logic          timeout;

   assign inh_last = (inh_cnt_q == IW'(INHIBIT_CYCLES - 1));
   assign timeout  = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge anti_reset) begin
      if (!anti_reset) begin
         state_q   <= StIdle;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_oe_q <= 1'b0;
         ack_q     <= 1'b1;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_oe_q <= data_oe_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      inh_cnt_d = inh_cnt_q;
      to_cnt_d  = to_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_oe_d = data_oe_q;
      ack_d     = ack_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            data_oe_d = 1'b0;
            if (tx_if.tx_valid) begin
               // Frame tail {stop, parity, data}; a 1 shifts in behind so bit 10 releases.
               shift_d   = {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
               inh_cnt_d = '0;
               state_d   = StInhibit;
            end
         end
         StInhibit: begin
            if (inh_last) begin
               data_oe_d = 1'b1;  // start bit stays driven after the clock is released
               to_cnt_d  = '0;
               bit_cnt_d = '0;
               state_d   = StSend;
            end else begin
               inh_cnt_d = inh_cnt_q + IW'(1);
            end
         end
         StSend: begin
            if (fall) begin
               to_cnt_d  = '0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd10) begin
                  ack_d   = filt_q[1];
                  state_d = StAck;
               end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = {1'b1, shift_q[9:1]};
               end
            end else if (timeout) begin
               error_d   = 1'b1;
               data_oe_d = 1'b0;
               state_d   = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         StAck: begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (ack_q) begin
               error_d = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = StWaitIdle;
            end
         end
         StWaitIdle: begin
            if (lines_idle) begin
               done_d  = 1'b1;
               state_d = StDone;
            end else if (fall) begin
               to_cnt_d = '0;
            end else if (timeout) begin
               error_d   = 1'b1;
               data_oe_d = 1'b0;
               state_d   = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         StDone: begin
            // Holds tx_ready low during the tx_done pulse.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ps2_clk_oe     = (state_q == StInhibit);
   assign ps2_data_oe    = data_oe_q | ((state_q == StInhibit) & inh_last);
   assign tx_if.tx_ready = (state_q == StIdle);
   assign tx_if.busy     = (state_q != StIdle);
   assign tx_if.tx_done  = done_q;
   assign tx_if.tx_error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

   localparam int unsigned INH = 50;
   localparam int unsigned TO  = 3000;
   localparam int unsigned FL  = 8;
   localparam int          HP  = 40;  // device clock half period in system cycles

   logic clock = 1'b0;
   logic anti_reset = 1'b0;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   logic ps2_clk_oe, ps2_data_oe;
   logic ps2_clk_line, ps2_data_line;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [10:0] exp_frame[$];
   bit          exp_res[$];  // 1 = tx_done expected, 0 = tx_error expected

   ps2_host_tx_if bus ();

   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .FILTER_LEN    (FL)
   ) dut (
      .clock      (clock),
      .anti_reset (anti_reset),
      .tx_if      (bus),
      .ps2_clk_in (ps2_clk_line),
      .ps2_data_in(ps2_data_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   always #10 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
      return {1'b1, p, d, 1'b0};
   endfunction

   // Result monitor: pops the expected outcome whenever the DUT pulses done or error.
   logic done_prev = 1'b0;
   always @(negedge clock) begin
      if (bus.tx_done || bus.tx_error) begin
         check("done_error_exclusive", {31'd0, bus.tx_done & bus.tx_error}, 0);
         if (exp_res.size() == 0) begin
            check("unexpected_pulse", {30'd0, bus.tx_done, bus.tx_error}, 0);
         end else begin
            check("result_done", {31'd0, bus.tx_done}, {31'd0, exp_res.pop_front()});
         end
         if (bus.tx_done) check("done_width", {31'd0, done_prev}, 0);
      end
      done_prev = bus.tx_done;
   end

   // Inhibit monitor: each request holds the clock low INH cycles, start bit in the last one.
   int run = 0;
   int rise_pos = 0;
   always @(negedge clock) begin
      if (ps2_clk_oe) begin
         run++;
         if (ps2_data_oe && rise_pos == 0) rise_pos = run;
      end else if (run != 0) begin
         check("inhibit_len", run, INH);
         check("start_bit_pos", rise_pos, INH);
         run = 0;
         rise_pos = 0;
      end
   end

   initial begin
      repeat (80000) @(posedge clock);
      $display("FAIL watchdog: bench did not complete, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic issue(input logic [7:0] d);
      int n = 0;
      @(negedge clock);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && n < 5000) begin
         @(negedge clock);
         n++;
      end
      if (!bus.tx_ready) check("issue_ready", 0, 1);
      @(negedge clock);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.tx_ready && n < 5000) begin
         @(negedge clock);
         n++;
      end
      if (!bus.tx_ready) check("wait_ready", 0, 1);
   endtask

   // Device model: answers one request, samples the line at the end of each clock-high phase.
   task automatic device(input int n_edges, input bit ack, input int glitch_k);
      logic [10:0] fr;
      int n;
      fr = '0;
      n  = 0;
      while (!ps2_clk_oe && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (!ps2_clk_oe) begin
         check("request_seen", 0, 1);
         return;
      end
      n = 0;
      while (ps2_clk_oe && n < int'(INH) + 20) begin
         @(negedge clock);
         n++;
      end
      if (ps2_clk_oe) begin
         check("request_release", 0, 1);
         return;
      end
      for (int k = 1; k <= n_edges; k++) begin
         if (glitch_k == k) begin
            repeat (HP / 2) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (3) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (HP / 2 - 3) @(negedge clock);
         end else begin
            repeat (HP) @(negedge clock);
         end
         fr[k-1] = ps2_data_line;
         if (k == 11 && ack) dev_data_low = 1'b1;
         dev_clk_low = 1'b1;
         if (k == n_edges && n_edges < 11) begin
            repeat (16) @(negedge clock);
            return;
         end
         repeat (HP) @(negedge clock);
         dev_clk_low = 1'b0;
      end
      dev_data_low = 1'b0;
      if (exp_frame.size() == 0) check("frame_unexpected", {21'd0, fr}, 0);
      else check("frame", {21'd0, fr}, {21'd0, exp_frame.pop_front()});
   endtask

   task automatic xfer(input logic [7:0] d, input logic p, input bit ack, input int glitch_k);
      exp_frame.push_back(mk_frame(d, p));
      exp_res.push_back(ack);
      fork
         issue(d);
         device(11, ack, glitch_k);
      join
      wait_ready();
      repeat (5) @(negedge clock);
   endtask

   initial begin
      int n, s, d_cyc, a_cyc;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_tx_ready", {31'd0, bus.tx_ready}, 1);
      check("rst_busy", {31'd0, bus.busy}, 0);
      check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check("rst_data_oe", {31'd0, ps2_data_oe}, 0);
      check("rst_tx_done", {31'd0, bus.tx_done}, 0);
      check("rst_tx_error", {31'd0, bus.tx_error}, 0);
      anti_reset = 1'b1;
      repeat (5) @(negedge clock);

      // Frames with hand-computed odd parity.
      xfer(8'hED, 1'b1, 1'b1, 0);
      xfer(8'h00, 1'b1, 1'b1, 0);
      xfer(8'h01, 1'b0, 1'b1, 0);
      xfer(8'hFF, 1'b1, 1'b1, 0);

      // Device withholds the ack.
      xfer(8'h96, 1'b1, 1'b0, 0);
      check("nack_ready", {31'd0, bus.tx_ready}, 1);
      check("nack_busy", {31'd0, bus.busy}, 0);

      // Silent device: error exactly TO cycles after the clock is released.
      exp_res.push_back(1'b0);
      issue(8'h42);
      n = 0;
      while (ps2_clk_oe && n < int'(INH) + 20) begin
         @(negedge clock);
         n++;
      end
      s = cyc;
      n = 0;
      while (!bus.tx_error && n < int'(TO) + 100) begin
         @(negedge clock);
         n++;
      end
      check("timeout_cycles", cyc - s, TO);
      check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
      wait_ready();
      repeat (5) @(negedge clock);

      // Valid while busy is ignored; a held valid is taken right after tx_done.
      exp_frame.push_back(mk_frame(8'h3C, 1'b1));
      exp_frame.push_back(mk_frame(8'hF4, 1'b0));
      exp_res.push_back(1'b1);
      exp_res.push_back(1'b1);
      fork
         begin
            issue(8'h3C);
            repeat (200) @(negedge clock);
            bus.tx_data  = 8'h55;
            bus.tx_valid = 1'b1;
            @(negedge clock);
            bus.tx_valid = 1'b0;
            @(negedge clock);
            bus.tx_data  = 8'hF4;
            bus.tx_valid = 1'b1;
            n = 0;
            while (!bus.tx_done && n < 3000) begin
               @(negedge clock);
               n++;
            end
            d_cyc = cyc;
            n = 0;
            while (!bus.tx_ready && n < 20) begin
               @(negedge clock);
               n++;
            end
            a_cyc = cyc;
            check("b2b_accept_cycle", a_cyc - d_cyc, 1);
            @(negedge clock);
            bus.tx_valid = 1'b0;
         end
         begin
            device(11, 1'b1, 0);
            device(11, 1'b1, 0);
         end
      join
      wait_ready();
      repeat (5) @(negedge clock);

      // A 3-cycle clock glitch must not advance a bit.
      xfer(8'hC3, 1'b1, 1'b1, 4);

      // Reset after the 5th falling edge: bit 4 of 0x02 is 0, so data is being pulled low.
      fork
         issue(8'h02);
         device(5, 1'b1, 0);
      join
      check("pre_reset_data_oe", {31'd0, ps2_data_oe}, 1);
      anti_reset = 1'b0;
      #1;
      check("reset_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
      check("reset_busy", {31'd0, bus.busy}, 0);
      check("reset_ready", {31'd0, bus.tx_ready}, 1);
      check("reset_pulses", {30'd0, bus.tx_done, bus.tx_error}, 0);
      repeat (3) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (2) @(negedge clock);
      anti_reset = 1'b1;
      repeat (5) @(negedge clock);
      xfer(8'h5A, 1'b1, 1'b1, 0);

      repeat (20) @(negedge clock);
      check("results_pending", exp_res.size(), 0);
      check("frames_pending", exp_frame.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the opposite direction of the keyboard/mouse receive path already behind the VGA controller's `ps2_clk`/`ps2_data` pins. It accepts one command byte through a valid/ready handshake, performs the PS/2 request-to-send sequence, and shifts out 8 data bits, odd parity and stop on device-generated clock edges. It then checks the device acknowledge and reports done or error. It runs on the 50 MHz system `clock`. It drives the bidirectional lines only through open-drain enables, so the top level can share the pins with the receiver.

## Interface
- `INHIBIT_CYCLES`, 5000: cycles `ps2_clk` is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum cycles between consecutive expected device edges (15 ms).
- `FILTER_LEN`, 8: consecutive equal synchronized samples needed to change the filtered line level.

- `clock` in 1: system clock, 50 MHz.
- `anti_reset` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send, LSB first.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: block can accept a byte.
- `ps2_clk_in` in 1: raw pin level of `ps2_clk`.
- `ps2_data_in` in 1: raw pin level of `ps2_data`.
- `ps2_clk_oe` out 1: 1 pulls `ps2_clk` low. At 0 the top level leaves the pin high-Z.
- `ps2_data_oe` out 1: 1 pulls `ps2_data` low. At 0 the pin is high-Z.
- `busy` out 1: a transfer is in progress.
- `tx_done` out 1: one-cycle pulse when a transfer has been acknowledged.
- `tx_error` out 1: one-cycle pulse when a transfer fails (timeout or missing ack).

## Operation
- **Input conditioning.** Each input passes through a 2-FF synchronizer, then a FILTER_LEN-sample agreement filter. Filtered levels reset to 1.
- **Edge detection.** A falling edge is the filtered clock going from 1 to 0.
- **Handshake.** A byte is accepted on a cycle where `tx_valid` and `tx_ready` are both 1.
  - The byte is latched into a shift register.
  - Parity is computed as `~^tx_data`.
  - `tx_valid` is ignored while `tx_ready` is 0.
- **States:**
  - IDLE: `tx_ready` = 1, both oe = 0. On accept, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe` = 1 for INHIBIT_CYCLES cycles. `ps2_data_oe` also rises in the final INHIBIT cycle (start bit). Then go to SEND.
  - SEND: `ps2_clk_oe` = 0 and the device clocks the bits. On each filtered falling edge k:
    - k = 1..8: `ps2_data_oe` = ~data[k-1].
    - k = 9: `ps2_data_oe` = ~parity.
    - k = 10: `ps2_data_oe` = 0 (stop bit, line released).
    - k = 11: go to ACK.
  - ACK: the filtered data level is sampled at the 11th falling edge. 0 means the device acknowledged; go to WAIT_IDLE. 1 raises `tx_error` and returns to IDLE.
  - WAIT_IDLE: wait until both filtered lines are 1, then raise `tx_done` and return to IDLE.
- **Timeout.** A counter reloads on every filtered falling edge and on entry to SEND. If it reaches TIMEOUT_CYCLES in SEND or WAIT_IDLE:
  - `tx_error` pulses;
  - both oe go to 0;
  - the block returns to IDLE.
- `busy` = 1 in every state except IDLE.
- `tx_done` and `tx_error` are never both 1 in the same cycle.

## Timing
- **Reset.** While `anti_reset` = 0, all state is cleared asynchronously:
  - `ps2_clk_oe` = `ps2_data_oe` = 0;
  - `tx_ready` = 1, `busy` = 0;
  - `tx_done` = `tx_error` = 0.
  - Reset in the middle of a transfer releases both lines in the same instant. No done or error pulse is produced.
- **Accept timing.** With the accept at cycle N:
  - `tx_ready` = 0 and `ps2_clk_oe` = 1 from cycle N+1;
  - `ps2_data_oe` = 1 from cycle N+INHIBIT_CYCLES;
  - `ps2_clk_oe` = 0 from cycle N+INHIBIT_CYCLES+1.
- **Edge latency.** Data drive changes FILTER_LEN+3 cycles after the raw `ps2_clk_in` falls. This is far under the device's clock-low half period of ≥30 µs.
- **Completion pulses.** `tx_done` pulses the cycle after both filtered lines are seen high. `tx_ready` returns to 1 the following cycle. A byte can be accepted in that same cycle.
- **Glitches.** A clock glitch shorter than FILTER_LEN cycles produces no edge.

## Test plan
- **Send 0xED with a device model** (10 kHz clock, ack driven): check all of the following, then `tx_done` = 1 for one cycle.
  - `ps2_clk_oe` high for exactly 5000 cycles.
  - Bits seen on the device's rising edges are 0(start),1,0,1,1,0,1,1,1,parity 1,stop 1.
- **Parity cases:** 0x00 → parity 1; 0x01 → parity 0; 0xFF → parity 1.
- **No acknowledge:** device leaves data high at the 11th edge → `tx_error` pulse, no `tx_done`, `tx_ready` = 1 afterwards.
- **Silent device** (no clocks after the request) → `tx_error` exactly TIMEOUT_CYCLES after entering SEND, both oe = 0.
- **`tx_valid` while busy, and back-to-back bytes:**
  - Pulse `tx_valid` with 0x55 in the middle of a transfer → ignored.
  - Hold `tx_valid` with 0xF4 → accepted in the first cycle `tx_ready` = 1 after `tx_done`.
- **Robustness:**
  - Assert `anti_reset` = 0 after the 5th falling edge → both oe drop immediately, `busy` = 0, no pulses. A new byte is accepted after release.
  - Inject a 3-cycle clock glitch → no bit is advanced.
